// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard, forwarding and flush controller for the 5-stage pipe.
//               A scoreboard shift pipeline holds the destination of every
//               in-flight instruction after decode. Operand forwarding
//               selects, load-use stalls/bubbles and the fetch flush for
//               decode-resolved branches and jumps come out of this block.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FW         = 2,
    parameter int CNT_W      = 16
) (
    input  logic              SYS_clk,
    input  logic              SYS_reset,
    input  logic              D_valid,
    input  logic [REG_AW-1:0] D_rs,
    input  logic [REG_AW-1:0] D_rt,
    input  logic              D_uses_rs,
    input  logic              D_uses_rt,
    input  logic              D_RegWrite,
    input  logic              D_MemRead,
    input  logic [REG_AW-1:0] D_write_register,
    input  logic              D_branch_taken,
    input  logic              D_jump,
    output logic              HZ_stall,
    output logic              HZ_bubble,
    output logic              HZ_flush_F,
    output logic [FW-1:0]     HZ_fwd_rs_sel,
    output logic [FW-1:0]     HZ_fwd_rt_sel,
    output logic [CNT_W-1:0]  HZ_stall_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    // Scoreboard: index k is the instruction currently in post-decode stage k.
    logic [NSTAGE:1]   r_sb_valid;
    logic [NSTAGE:1]   r_sb_regwrite;
    logic [NSTAGE:1]   r_sb_memread;
    logic [REG_AW-1:0] r_sb_dest [1:NSTAGE];
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [FW-1:0]     w_rs_sel;
    logic [FW-1:0]     w_rt_sel;
    logic              w_rs_haz;
    logic              w_rt_haz;
    logic              w_stall;

    // Youngest-match search per source. Scanning from the oldest stage down
    // lets the youngest match overwrite older ones, so a not-yet-ready young
    // load masks any older ready writer of the same register.
    always_comb begin
        w_rs_sel = '0;
        w_rs_haz = 1'b0;
        w_rt_sel = '0;
        w_rt_haz = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (D_uses_rs && (D_rs != '0) && r_sb_valid[k] && r_sb_regwrite[k] &&
                (r_sb_dest[k] == D_rs)) begin
                if (!r_sb_memread[k] || (k >= LOAD_STAGE)) begin
                    w_rs_sel = FW'(k);
                    w_rs_haz = 1'b0;
                end else begin
                    w_rs_sel = '0;
                    w_rs_haz = 1'b1;
                end
            end
            if (D_uses_rt && (D_rt != '0) && r_sb_valid[k] && r_sb_regwrite[k] &&
                (r_sb_dest[k] == D_rt)) begin
                if (!r_sb_memread[k] || (k >= LOAD_STAGE)) begin
                    w_rt_sel = FW'(k);
                    w_rt_haz = 1'b0;
                end else begin
                    w_rt_sel = '0;
                    w_rt_haz = 1'b1;
                end
            end
        end
    end

    assign w_stall = D_valid && (w_rs_haz || w_rt_haz);

    // Outputs are forced low while reset is held, independent of stale state.
    assign HZ_stall       = !SYS_reset && w_stall;
    assign HZ_bubble      = !SYS_reset && w_stall;
    assign HZ_flush_F     = !SYS_reset && D_valid && !w_stall && (D_branch_taken || D_jump);
    assign HZ_fwd_rs_sel  = (SYS_reset || !D_valid) ? '0 : w_rs_sel;
    assign HZ_fwd_rt_sel  = (SYS_reset || !D_valid) ? '0 : w_rt_sel;
    assign HZ_stall_count = SYS_reset ? '0 : r_stall_cnt;

    // Scoreboard advance on the pipeline-register edge; a bubble enters EX
    // as an invalid entry while the decode instruction is held.
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            r_sb_valid    <= '0;
            r_sb_regwrite <= '0;
            r_sb_memread  <= '0;
            for (int k = 1; k <= NSTAGE; k++) begin
                r_sb_dest[k] <= '0;
            end
        end else begin
            for (int k = 2; k <= NSTAGE; k++) begin
                r_sb_valid[k]    <= r_sb_valid[k-1];
                r_sb_regwrite[k] <= r_sb_regwrite[k-1];
                r_sb_memread[k]  <= r_sb_memread[k-1];
                r_sb_dest[k]     <= r_sb_dest[k-1];
            end
            r_sb_valid[1]    <= D_valid && !w_stall;
            r_sb_regwrite[1] <= D_RegWrite;
            r_sb_memread[1]  <= D_MemRead;
            r_sb_dest[1]     <= D_write_register;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(negedge SYS_clk) begin
        if (SYS_reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
Parametrised hazard, forwarding and flush controller for the 5-stage pipelined processor.
- Tracks the destinations of in-flight instructions in an internal scoreboard shift pipeline, one entry per post-decode stage.
- Drives the decode-stage operand forwarding selects, load-use stalls with bubble insertion, and fetch flush for taken branches and jumps.
- Sits beside decode_stage. Branches resolve in decode, so operands are forwarded into the decode compare and the EX operand latch.

Parameters:
REG_AW, 5, register address width
NSTAGE, 3, number of tracked in-flight stages after decode (1=EX, 2=MEM, 3=WB)
LOAD_STAGE, 2, first stage index whose output holds valid load data (2..NSTAGE)
FW, 2, forwarding select width; must satisfy 2^FW >= NSTAGE+1
CNT_W, 16, stall performance counter width

Ports:
SYS_clk  in  1  system clock
SYS_reset  in  1  synchronous active-high reset
D_valid  in  1  decode register holds a real instruction
D_rs  in  REG_AW  source register rs
D_rt  in  REG_AW  source register rt
D_uses_rs  in  1  instruction reads rs
D_uses_rt  in  1  instruction reads rt
D_RegWrite  in  1  instruction writes a register
D_MemRead  in  1  instruction is a load
D_write_register  in  REG_AW  destination register
D_branch_taken  in  1  decode-resolved branch is taken (beq/bne)
D_jump  in  1  decode holds a jump
HZ_stall  out  1  hold PC and the F->D register
HZ_bubble  out  1  load a NOP (all controls 0) into EX
HZ_flush_F  out  1  load a NOP into the F->D register at the next edge
HZ_fwd_rs_sel  out  FW  0 = register file; k = result of stage k
HZ_fwd_rt_sel  out  FW  as above, for rt
HZ_stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
Clocking and reset
- One clock, SYS_clk. Reset is synchronous and active-high on SYS_reset.
- State updates on the falling edge of SYS_clk, the same edge as the pipeline registers.
- Reset clears all scoreboard entries to invalid and HZ_stall_count to 0. All outputs read 0 while reset is held.
- Reset mid-stall clears everything; HZ_stall is 0 on the cycle after reset.

Scoreboard
- Entry k (1..NSTAGE) holds {valid, regwrite, memread, dest}.
- Each edge, entry k <= entry k-1, for k = 2..NSTAGE.
- Entry 1 <= decode fields when D_valid && !HZ_bubble; otherwise entry 1 <= invalid.

Forwarding (combinational, per source s in {rs, rt})
- A stage k matches s when: uses_s, s != 0, entry k valid, regwrite set, dest == s.
- Select the youngest matching stage (lowest k). No match, or s == 0: select 0.
- The matched entry is ready if memread=0, or if k >= LOAD_STAGE.
- Selected and ready: HZ_fwd_s_sel = k.
- Selected but not ready: hazard. HZ_fwd_s_sel = 0, and an older ready match is not used.

Stall
- HZ_stall = HZ_bubble = D_valid && (hazard on rs || hazard on rt).
- Defaults give a load-use penalty of 1 cycle (LOAD_STAGE=2) and no ALU-use penalty.
- This applies equally to branch operands.

Flush
- HZ_flush_F = D_valid && !HZ_stall && (D_branch_taken || D_jump). Asserted for one cycle.
- When a stall and a taken branch occur together, the stall wins: flush stays 0 and the branch is re-evaluated next cycle with forwarded operands.

Counter
- HZ_stall_count increments on every edge where HZ_stall=1.
- It saturates at 2^CNT_W-1 and never wraps.

Outputs and invalid decode
- All outputs other than the counter are combinational from the scoreboard and decode inputs.
- With D_valid=0: no stall, no flush, selects 0.

Test Plan:
- Reset: hold SYS_reset 2 cycles with D_valid=1 and a load in flight -> all outputs 0, count 0; the first post-reset cycle shows no stall.
- ALU-use: add $8 followed immediately by sub $9,$8,$8 -> rs_sel=1, rt_sel=1, stall=0; one cycle later an unrelated reader of $8 gets sel=2.
- Load-use: lw $9 then add $10,$9,$1 -> stall=bubble=1 for exactly 1 cycle, then rs_sel=2, stall=0; count=1. With LOAD_STAGE=3 -> 2 stall cycles, then sel=3.
- Youngest wins: writers to $10 in stage 3 (ALU) and stage 1 (ALU) -> sel=1. Stage-1 writer a load instead -> stall=1, sel=0.
- Register zero: add $0 then a reader of $0 -> sel=0, no stall, even when the writer is a load.
- Flush: taken beq with no hazard -> flush_F=1 for 1 cycle. beq $9,$2 right after lw $9 -> cycle 1 stall=1, flush_F=0; cycle 2 rs_sel=2, flush_F=1. Counter preset near max -> saturates at 65535.
